// File: rtl/rto_pkg.sv
// Shared widths and entry layout for the timestamped GPO output queue.
package rto_pkg;

  localparam int TS_WIDTH_DEF   = 64;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef struct packed {
    logic [63:0]  ts;
    logic [127:0] data;
  } rto_entry_t;

  // Occupancy counter must represent both 0 and DEPTH.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rto_timed_fifo_if.sv
// Write-side and GPO-side signal bundle of the timed FIFO.
interface rto_timed_fifo_if
  import rto_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic                  fifo_flush;
  logic                  wr_en;
  logic [TS_WIDTH-1:0]   wr_timestamp;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         data_count;
  logic                  counter_matched;
  logic [DATA_WIDTH-1:0] gpo_data;

  modport master (
    output fifo_flush, wr_en, wr_timestamp, wr_data,
    input  full, empty, data_count, counter_matched, gpo_data
  );

  modport slave (
    input  fifo_flush, wr_en, wr_timestamp, wr_data,
    output full, empty, data_count, counter_matched, gpo_data
  );

endinterface

// File: rtl/rto_sync_fifo.sv
// Generic first-word-fall-through circular buffer with flush; head is read
// combinationally from the read pointer.
module rto_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 192
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign do_rd = rd_en & ~empty & ~flush;
  assign do_wr = wr_en & (~full | do_rd) & ~flush;

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which words are valid, and leaving it reset-free lets it map to RAM.
  always_ff @(posedge CLK100MHZ) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK100MHZ) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/rto_timed_fifo.sv
// Timestamped output queue feeding the GPO core: fires the head payload one
// cycle after the timeline counter reaches its timestamp, drops late entries.
module rto_timed_fifo
  import rto_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic [TS_WIDTH-1:0] counter,
  rto_timed_fifo_if.slave     bus,
  output logic                timestamp_error,
  output logic                overflow_error
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                wr_entry;
  entry_t                head;
  logic                  due;
  logic                  fire;
  logic                  late;
  logic                  pop;
  logic                  strobe_q;
  logic [DATA_WIDTH-1:0] gpo_q;

  assign wr_entry = '{ts: bus.wr_timestamp, data: bus.wr_data};

  // Flush wins over pop, so nothing fires or is flagged in a flush cycle.
  assign due  = ~bus.empty & ~bus.fifo_flush;
  assign fire = due & (head.ts == counter);
  assign late = due & (head.ts < counter);
  assign pop  = fire | late;

  rto_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(TS_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .CLK100MHZ(CLK100MHZ),
    .reset    (reset),
    .flush    (bus.fifo_flush),
    .wr_en    (bus.wr_en),
    .wr_data  (wr_entry),
    .rd_en    (pop),
    .full     (bus.full),
    .empty    (bus.empty),
    .count    (bus.data_count),
    .head     (head)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      strobe_q        <= 1'b0;
      gpo_q           <= '0;
      timestamp_error <= 1'b0;
      overflow_error  <= 1'b0;
    end else begin
      strobe_q <= fire;
      if (fire) gpo_q <= head.data;
      if (bus.fifo_flush) begin
        timestamp_error <= 1'b0;
        overflow_error  <= 1'b0;
      end else begin
        if (late) timestamp_error <= 1'b1;
        if (bus.wr_en && bus.full && !pop) overflow_error <= 1'b1;
      end
    end
  end

  assign bus.counter_matched = strobe_q;
  assign bus.gpo_data        = gpo_q;

endmodule
